// File: rtl/bcd_display_mux_if.sv
// ---------------------------------------------------------------------------
// bcd_display_mux_if
// Bundle of the data-path signals of bcd_display_mux. Clock and reset stay
// plain ports on the module.
//   tick_i      scan strobe, one-cycle pulse
//   digits_i    four packed BCD digits, [3:0] = digit 0
//   dp_i        decimal point request, bit n = digit n
//   lz_blank_i  blank digit 3 when it is zero
//   seg_o       segments g..a, active-high
//   dp_o        decimal point segment
//   digit_sel_o one-hot (or zero) digit enable
//   frame_o     one-cycle pulse when a frame starts at digit 0
// master: drives the inputs (system side); slave: the display mux itself.
// ---------------------------------------------------------------------------
interface bcd_display_mux_if;
  logic        tick_i;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic        lz_blank_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  digit_sel_o;
  logic        frame_o;

  modport master (
    output tick_i, digits_i, dp_i, lz_blank_i,
    input  seg_o, dp_o, digit_sel_o, frame_o
  );

  modport slave (
    input  tick_i, digits_i, dp_i, lz_blank_i,
    output seg_o, dp_o, digit_sel_o, frame_o
  );
endinterface

// File: rtl/bcd_display_mux.sv
// ---------------------------------------------------------------------------
// bcd_display_mux
// Time-multiplexed driver for a four-digit 7-segment display. Each digit is
// lit for DWELL_TICKS scan strobes, followed by GAP_TICKS strobes with every
// output dark, so two digits are never driven on adjacent cycles. The input
// digits, decimal points and blanking flag are snapshotted once per frame,
// on the edge that wraps the scan back to digit 0, so a frame never tears.
// All outputs are registered.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous active-high reset
//   bus    bcd_display_mux_if.slave (tick, digits, dp, blanking in;
//          segments, dp, digit select, frame pulse out)
//
// state | meaning
// ------+-----------------------------------------------------------
// SHOW  | digit at idx_q is driven, counting DWELL_TICKS strobes
// GAP   | all outputs dark, counting GAP_TICKS strobes
// ---------------------------------------------------------------------------
module bcd_display_mux #(
  parameter int unsigned DWELL_TICKS = 4,
  parameter int unsigned GAP_TICKS   = 1
) (
  input logic               clk_i,
  input logic               rst_i,
  bcd_display_mux_if.slave  bus
);

  typedef enum logic {ST_SHOW, ST_GAP} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_TICKS - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_TICKS - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] dig_sh_q, dig_sh_d;
  logic [3:0]  dp_sh_q, dp_sh_d;
  logic        lz_sh_q, lz_sh_d;
  logic [6:0]  seg_q, seg_d;
  logic        dpo_q, dpo_d;
  logic [3:0]  sel_q, sel_d;
  logic        frame_q, frame_d;

  logic [1:0]  idx_nxt;
  logic        wrap;
  logic [15:0] dig_src;
  logic [3:0]  dp_src;
  logic        lz_src;
  logic [3:0]  nib;

  function automatic logic [6:0] decode(input logic [3:0] val);
    logic [6:0] s;
    case (val)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;  // non-BCD nibble shows a dash
    endcase
    return s;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dig_sh_d = dig_sh_q;
    dp_sh_d  = dp_sh_q;
    lz_sh_d  = lz_sh_q;
    seg_d    = seg_q;
    dpo_d    = dpo_q;
    sel_d    = sel_q;
    frame_d  = 1'b0;  // pulse lasts one cycle regardless of tick

    // Leaving GAP selects idx_q+1. On the wrap to digit 0 the snapshot is
    // taken on the same edge, so digit 0 must decode straight from the inputs.
    idx_nxt = idx_q + 2'd1;
    wrap    = (idx_nxt == 2'd0);
    dig_src = wrap ? bus.digits_i   : dig_sh_q;
    dp_src  = wrap ? bus.dp_i       : dp_sh_q;
    lz_src  = wrap ? bus.lz_blank_i : lz_sh_q;
    nib     = dig_src[{idx_nxt, 2'b00} +: 4];

    if (bus.tick_i) begin
      case (state_q)
        ST_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ST_GAP;
            cnt_d   = 8'd0;
            seg_d   = 7'h00;
            dpo_d   = 1'b0;
            sel_d   = 4'b0000;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = 8'd0;
            idx_d   = idx_nxt;
            if (wrap) begin
              dig_sh_d = bus.digits_i;
              dp_sh_d  = bus.dp_i;
              lz_sh_d  = bus.lz_blank_i;
              frame_d  = 1'b1;
            end
            // Leading-zero blanking applies to the hours-tens digit only.
            if (idx_nxt == 2'd3 && lz_src && nib == 4'd0)
              seg_d = 7'h00;
            else
              seg_d = decode(nib);
            dpo_d = dp_src[idx_nxt];
            sel_d = 4'b0001 << idx_nxt;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_GAP;
          cnt_d   = 8'd0;
          seg_d   = 7'h00;
          dpo_d   = 1'b0;
          sel_d   = 4'b0000;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Index parks at 3 so the first completed GAP wraps to digit 0.
      state_q  <= ST_GAP;
      cnt_q    <= 8'd0;
      idx_q    <= 2'd3;
      dig_sh_q <= 16'h0000;
      dp_sh_q  <= 4'h0;
      lz_sh_q  <= 1'b0;
      seg_q    <= 7'h00;
      dpo_q    <= 1'b0;
      sel_q    <= 4'b0000;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dig_sh_q <= dig_sh_d;
      dp_sh_q  <= dp_sh_d;
      lz_sh_q  <= lz_sh_d;
      seg_q    <= seg_d;
      dpo_q    <= dpo_d;
      sel_q    <= sel_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.seg_o       = seg_q;
  assign bus.dp_o        = dpo_q;
  assign bus.digit_sel_o = sel_q;
  assign bus.frame_o     = frame_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_mux
// Directed bench for bcd_display_mux with DWELL_TICKS=2, GAP_TICKS=1.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
// ---------------------------------------------------------------------------
module tb_bcd_display_mux;

  logic clk_i = 1'b0;
  logic rst_i;

  int n_assert = 0;
  int n_fail   = 0;

  bcd_display_mux_if bus();

  bcd_display_mux #(
    .DWELL_TICKS (2),
    .GAP_TICKS   (1)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] sel,
                         input logic [6:0] seg, input logic dp);
    chk({tag, "_sel"}, 32'(bus.digit_sel_o), 32'(sel));
    chk({tag, "_seg"}, 32'(bus.seg_o), 32'(seg));
    chk({tag, "_dp"},  32'(bus.dp_o), 32'(dp));
  endtask

  // Steps until frame_o is seen, bounded so a dead DUT cannot hang the run.
  task automatic wait_frame(input string tag);
    int k;
    k = 0;
    step();
    while (bus.frame_o !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    chk({tag, "_frame_seen"}, 32'(bus.frame_o), 32'd1);
  endtask

  initial begin
    rst_i          = 1'b1;
    bus.tick_i     = 1'b1;
    bus.digits_i   = 16'h1234;
    bus.dp_i       = 4'b0100;
    bus.lz_blank_i = 1'b0;

    // Reset with tick active: reset wins, everything dark.
    steps(3);
    chk_out("rst", 4'b0000, 7'h00, 1'b0);
    chk("rst_frame", 32'(bus.frame_o), 32'd0);

    // Reset release: first GAP completes on the first edge.
    rst_i = 1'b0;
    step();
    chk_out("rel_d0", 4'b0001, 7'h66, 1'b0);
    chk("rel_frame1", 32'(bus.frame_o), 32'd1);
    step();
    chk_out("rel_d0_hold", 4'b0001, 7'h66, 1'b0);
    chk("rel_frame0", 32'(bus.frame_o), 32'd0);
    step();
    chk_out("rel_gap", 4'b0000, 7'h00, 1'b0);
    step();
    chk_out("rel_d1", 4'b0010, 7'h4F, 1'b0);

    // Decimal point on digit 2, none on digit 3.
    steps(3);
    chk_out("dp_d2", 4'b0100, 7'h5B, 1'b1);
    steps(3);
    chk_out("dp_d3", 4'b1000, 7'h06, 1'b0);
    steps(3);
    chk_out("wrap_d0", 4'b0001, 7'h66, 1'b0);
    chk("wrap_frame", 32'(bus.frame_o), 32'd1);

    // Hold: no ticks for 10 cycles while showing digit 0.
    bus.tick_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("hold", 4'b0001, 7'h66, 1'b0);
    end
    bus.tick_i = 1'b1;
    step();
    chk_out("resume_dwell", 4'b0001, 7'h66, 1'b0);
    step();
    chk_out("resume_gap", 4'b0000, 7'h00, 1'b0);
    step();
    chk_out("resume_d1", 4'b0010, 7'h4F, 1'b0);

    // New inputs mid-frame: digit 2 still comes from the old snapshot.
    bus.digits_i   = 16'h0907;
    bus.lz_blank_i = 1'b1;
    steps(3);
    chk_out("snap_d2", 4'b0100, 7'h5B, 1'b1);

    // Leading-zero blanking frame.
    wait_frame("lz1");
    chk_out("lz1_d0", 4'b0001, 7'h07, 1'b0);
    steps(3);
    chk_out("lz1_d1", 4'b0010, 7'h3F, 1'b0);
    steps(3);
    chk_out("lz1_d2", 4'b0100, 7'h6F, 1'b1);
    steps(3);
    chk_out("lz1_d3", 4'b1000, 7'h00, 1'b0);

    // Blanking off: digit 3 shows a zero.
    bus.lz_blank_i = 1'b0;
    wait_frame("lz0");
    chk_out("lz0_d0", 4'b0001, 7'h07, 1'b0);
    steps(9);
    chk_out("lz0_d3", 4'b1000, 7'h3F, 1'b0);

    // Snapshot plus bad BCD.
    wait_frame("bad");
    bus.digits_i = 16'h000A;
    steps(3);
    chk_out("bad_d1", 4'b0010, 7'h3F, 1'b0);
    steps(3);
    chk_out("bad_d2_old", 4'b0100, 7'h6F, 1'b1);
    wait_frame("bad_next");
    chk_out("bad_d0_dash", 4'b0001, 7'h40, 1'b0);

    // Reset mid-SHOW, then first frame exactly GAP_TICKS ticks later.
    rst_i = 1'b1;
    step();
    chk_out("midrst", 4'b0000, 7'h00, 1'b0);
    chk("midrst_frame", 32'(bus.frame_o), 32'd0);
    rst_i = 1'b0;
    step();
    chk("midrst_rel_frame", 32'(bus.frame_o), 32'd1);
    chk_out("midrst_rel_d0", 4'b0001, 7'h40, 1'b0);

    // Reset mid-GAP.
    steps(2);
    chk_out("gap_pre", 4'b0000, 7'h00, 1'b0);
    rst_i = 1'b1;
    step();
    chk_out("gaprst", 4'b0000, 7'h00, 1'b0);
    rst_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_display_mux.md
BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 The module SHALL have one clock and one reset: clock clk_i, reset rst_i, synchronous, active-high.
REQ-002 Parameter DWELL_TICKS, default 4: the number of tick_i strobes each digit stays lit, legal range 1..255.
REQ-003 Parameter GAP_TICKS, default 1: the number of tick_i strobes all digits stay dark between two digits, legal range 1..255.
REQ-004 clk_i  input  1  system clock.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 tick_i  input  1  scan strobe; one-cycle pulse that advances scan timing.
REQ-007 digits_i  input  16  four BCD digits; [3:0] is digit 0 (minutes ones), [15:12] is digit 3 (hours tens).
REQ-008 dp_i  input  4  decimal point request per digit; bit n belongs to digit n.
REQ-009 lz_blank_i  input  1  when set, digit 3 is blanked if its value is 0.
REQ-010 seg_o  output  7  segments, active-high; bit0=a, bit1=b, and so on up to bit6=g.
REQ-011 dp_o  output  1  decimal point segment, active-high.
REQ-012 digit_sel_o  output  4  digit enable, one-hot or all-zero, active-high.
REQ-013 frame_o  output  1  one-cycle pulse when a new frame starts at digit 0.

Function
REQ-014 The FSM SHALL have two states: SHOW, where one digit is driven, and GAP, where all outputs are dark.
REQ-015 The block SHALL hold a tick counter (8-bit), a digit index (2-bit) and a shadow copy of digits_i, dp_i and lz_blank_i.
REQ-016 In a cycle where tick_i=0, the state, counter, index, shadow and all outputs SHALL hold.
REQ-017 In SHOW with tick_i=1 and counter < DWELL_TICKS-1, the counter SHALL increment.
REQ-018 In SHOW with tick_i=1 and counter = DWELL_TICKS-1:
- the FSM SHALL go to GAP and the counter SHALL clear to 0;
- on the next cycle, seg_o, dp_o and digit_sel_o SHALL all be 0.
REQ-019 In GAP with tick_i=1 and counter < GAP_TICKS-1, the counter SHALL increment.
REQ-020 In GAP with tick_i=1 and counter = GAP_TICKS-1:
- the index SHALL advance by 1, wrapping from 3 to 0;
- the FSM SHALL go to SHOW and the counter SHALL clear;
- on the next cycle, the outputs SHALL drive the new digit.
REQ-021 When the index wraps to 0, on that same transition edge:
- the shadow SHALL capture digits_i, dp_i and lz_blank_i;
- frame_o SHALL be 1 for exactly the next cycle.
REQ-022 Digit 0 SHALL display the values captured on that edge.
REQ-023 Input changes SHALL NOT affect the display until the next frame, so there is no tearing.
REQ-024 All outputs SHALL be registered.
REQ-025 Output changes SHALL appear exactly one cycle after the clock edge that samples the qualifying tick_i.
REQ-026 In SHOW, digit_sel_o SHALL equal 1 << index, and dp_o SHALL equal the shadow dp bit for that index.
REQ-027 Decode SHALL be (hex, g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
REQ-028 A non-BCD nibble (A..F) SHALL display 40 (segment g only, a dash).
REQ-029 If index=3, the shadow lz_blank=1 and the shadow digit 3 = 0:
- seg_o SHALL be 00;
- digit_sel_o SHALL still be 1000 and dp_o SHALL still follow the shadow.
REQ-030 No other digit SHALL ever be zero-blanked.
REQ-031 digit_sel_o SHALL never have more than one bit set.
REQ-032 digit_sel_o SHALL never be nonzero in a cycle where the previous cycle showed a different digit; GAP always intervenes.

Reset
REQ-033 While rst_i=1, on each edge:
- state SHALL be GAP, counter 0, index 3, shadow 0;
- seg_o, dp_o, digit_sel_o and frame_o SHALL all be 0 on the following cycle.
REQ-034 Reset SHALL take priority over tick_i.
REQ-035 Reset asserted mid-SHOW or mid-GAP SHALL darken all outputs on the next cycle.
REQ-036 After reset is released, the first completed GAP SHALL wrap the index to 0, capture the shadow and pulse frame_o.

Verification
REQ-037 Scenario, reset release (DWELL=2, GAP=1, tick_i=1 every cycle, digits_i=1234 hex, dp_i=0100):
- cycle after the first post-reset edge: digit_sel_o=0001, seg_o=66, frame_o=1;
- the next cycle: digit_sel_o=0001 held, frame_o=0;
- then one dark cycle, then digit_sel_o=0010 with seg_o=4F.
REQ-038 Scenario, decimal point: same setup; at digit 2, seg_o=5B and dp_o=1; at digit 3, seg_o=06 and dp_o=0.
REQ-039 Scenario, hold: tick_i held at 0 for 10 cycles while in SHOW -> all outputs unchanged; scanning resumes on the next tick.
REQ-040 Scenario, leading zero:
- digits_i=0907 hex, lz_blank_i=1 -> digit 3 shows digit_sel_o=1000 with seg_o=00, digit 2 shows 6F;
- with lz_blank_i=0 -> digit 3 shows 3F.
REQ-041 Scenario, snapshot and bad BCD:
- digits_i changed to 000A mid-frame -> displayed digits unchanged until the next frame_o;
- on the next frame, digit 0 shows 40.
REQ-042 Scenario, reset mid-SHOW -> next cycle all outputs 0; first frame_o follows exactly GAP_TICKS ticks after release.
